regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 84 ++++++++
 tb/tb_regfile_sb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-write/two-read register file with per-register busy scoreboard
// Forwarding and the hardwired-zero register are selected by parameter.
module regfile_sb #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen0,
   input  logic [ADDR_WIDTH-1:0] waddr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic                  wen1,
   input  logic [ADDR_WIDTH-1:0] waddr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   output logic                  rbusy1,
   output logic                  rbusy2,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   output logic                  iss_ready,
   input  logic                  flush
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam bit BYP   = (BYPASS != 0);
   localparam bit ZR    = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0] rf [DEPTH];
   logic [DEPTH-1:0]      busy;

   logic w0_ok, w1_ok, iss_fire;
   logic hit1, hit2;

   assign w0_ok = wen0 && !(ZR && waddr0 == '0);
   assign w1_ok = wen1 && !(ZR && waddr1 == '0);

   assign iss_ready = (ZR && iss_rd == '0) ? 1'b1 : !busy[iss_rd];
   // Register 0 accepts issues but is never marked busy when hardwired.
   assign iss_fire  = iss_valid && iss_ready && !(ZR && iss_rd == '0);

   assign hit1 = (wen0 && waddr0 == raddr1) || (wen1 && waddr1 == raddr1);
   assign hit2 = (wen0 && waddr0 == raddr2) || (wen1 && waddr1 == raddr2);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            rf[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (w0_ok) rf[waddr0] <= wdata0;
         if (w1_ok) rf[waddr1] <= wdata1;
         // Statement order gives port 1 priority and lets an issue win over a write clear.
         if (flush) begin
            busy <= '0;
         end else begin
            if (wen0)     busy[waddr0] <= 1'b0;
            if (wen1)     busy[waddr1] <= 1'b0;
            if (iss_fire) busy[iss_rd] <= 1'b1;
         end
      end
   end

   always_comb begin
      rdata1 = rf[raddr1];
      if (BYP && wen0 && waddr0 == raddr1) rdata1 = wdata0;
      if (BYP && wen1 && waddr1 == raddr1) rdata1 = wdata1;
      if (ZR && raddr1 == '0)              rdata1 = '0;

      rdata2 = rf[raddr2];
      if (BYP && wen0 && waddr0 == raddr2) rdata2 = wdata0;
      if (BYP && wen1 && waddr1 == raddr2) rdata2 = wdata1;
      if (ZR && raddr2 == '0)              rdata2 = '0;
   end

   assign rbusy1 = busy[raddr1] && !(BYP && hit1) && !(ZR && raddr1 == '0);
   assign rbusy2 = busy[raddr2] && !(BYP && hit2) && !(ZR && raddr2 == '0);

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic        wen0, wen1;
   logic [4:0]  waddr0, waddr1;
   logic [31:0] wdata0, wdata1;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2;
   logic        rbusy1, rbusy2;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic        flush;

   int total = 0;
   int bad   = 0;

   regfile_sb dut (
      .clk(clk), .rst(rst),
      .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
      .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2),
      .rbusy1(rbusy1), .rbusy2(rbusy2),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wen0 = 0; wen1 = 0; iss_valid = 0; flush = 0; rst = 0;
   endtask

   initial begin
      idle();
      waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
      raddr1 = 0; raddr2 = 0; iss_rd = 0;
      rst = 1;
      tick(); tick();
      rst = 0;

      raddr1 = 5; raddr2 = 31; iss_rd = 5; #1;
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_rdata2", rdata2, 32'h0);
      chk("rst_rbusy1", 32'(rbusy1), 32'h0);
      chk("rst_rbusy2", 32'(rbusy2), 32'h0);
      chk("rst_iss_ready", 32'(iss_ready), 32'h1);

      // write r5 via port 0, forwarded the same cycle
      wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; #1;
      chk("w5_bypass", rdata1, 32'hDEADBEEF);
      tick(); idle(); #1;
      chk("w5_rdata1", rdata1, 32'hDEADBEEF);
      chk("w5_rbusy1", 32'(rbusy1), 32'h0);

      // both ports hit r7, port 1 wins
      wen0 = 1; waddr0 = 7; wdata0 = 32'h11;
      wen1 = 1; waddr1 = 7; wdata1 = 32'h22;
      raddr2 = 7; #1;
      chk("r7_bypass_prio", rdata2, 32'h22);
      tick(); idle(); #1;
      chk("r7_stored", rdata2, 32'h22);

      // issue r3, repeat is refused, write clears
      iss_valid = 1; iss_rd = 3; raddr1 = 3; #1;
      chk("iss3_ready", 32'(iss_ready), 32'h1);
      tick(); #1;
      chk("iss3_busy", 32'(rbusy1), 32'h1);
      chk("iss3_repeat_ready", 32'(iss_ready), 32'h0);
      tick(); idle(); #1;
      chk("iss3_still_busy", 32'(rbusy1), 32'h1);
      wen1 = 1; waddr1 = 3; wdata1 = 32'h5; #1;
      chk("w3_bypass_busy", 32'(rbusy1), 32'h0);
      chk("w3_bypass_data", rdata1, 32'h5);
      tick(); idle(); #1;
      chk("w3_busy_clear", 32'(rbusy1), 32'h0);
      chk("w3_iss_ready", 32'(iss_ready), 32'h1);
      chk("w3_data", rdata1, 32'h5);

      // register 0 is hardwired
      wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFF; raddr1 = 0; #1;
      chk("r0_bypass", rdata1, 32'h0);
      tick(); idle(); #1;
      chk("r0_rdata", rdata1, 32'h0);
      chk("r0_rbusy", 32'(rbusy1), 32'h0);
      iss_valid = 1; iss_rd = 0; #1;
      chk("r0_iss_ready", 32'(iss_ready), 32'h1);
      tick(); idle(); #1;
      chk("r0_busy_after_iss", 32'(rbusy1), 32'h0);
      chk("r0_iss_ready_after", 32'(iss_ready), 32'h1);

      // issue and write of r10 together: busy stays, data stored
      iss_valid = 1; iss_rd = 10; wen0 = 1; waddr0 = 10; wdata0 = 32'h77; raddr1 = 10;
      tick(); idle(); #1;
      chk("r10_busy", 32'(rbusy1), 32'h1);
      chk("r10_data", rdata1, 32'h77);

      // issue r4, r9, r12 then flush with issue r2 and a write of r6
      iss_valid = 1; iss_rd = 4;  tick();
      iss_rd = 9;  tick();
      iss_rd = 12; tick();
      iss_valid = 0; raddr1 = 4; raddr2 = 12; #1;
      chk("r4_busy", 32'(rbusy1), 32'h1);
      chk("r12_busy", 32'(rbusy2), 32'h1);
      flush = 1; iss_valid = 1; iss_rd = 2; wen0 = 1; waddr0 = 6; wdata0 = 32'h66;
      tick(); idle(); #1;
      chk("fl_r4", 32'(rbusy1), 32'h0);
      chk("fl_r12", 32'(rbusy2), 32'h0);
      raddr1 = 9; raddr2 = 2; #1;
      chk("fl_r9", 32'(rbusy1), 32'h0);
      chk("fl_r2", 32'(rbusy2), 32'h0);
      raddr1 = 10; raddr2 = 6; #1;
      chk("fl_r10", 32'(rbusy1), 32'h0);
      chk("fl_r6_data", rdata2, 32'h66);
      raddr1 = 5; #1;
      chk("fl_r5_data", rdata1, 32'hDEADBEEF);

      // reset discards pending state and same-cycle writes/issues
      wen0 = 1; waddr0 = 8; wdata0 = 32'hA5; tick(); idle();
      iss_valid = 1; iss_rd = 8; tick(); idle();
      raddr1 = 8; #1;
      chk("r8_busy_pre", 32'(rbusy1), 32'h1);
      chk("r8_data_pre", rdata1, 32'hA5);
      rst = 1; wen0 = 1; waddr0 = 9; wdata0 = 32'h99; iss_valid = 1; iss_rd = 11;
      tick(); idle();
      iss_rd = 8; raddr2 = 9; #1;
      chk("rst_r8_data", rdata1, 32'h0);
      chk("rst_r8_busy", 32'(rbusy1), 32'h0);
      chk("rst_r8_ready", 32'(iss_ready), 32'h1);
      chk("rst_r9_ignored", rdata2, 32'h0);
      raddr1 = 5; raddr2 = 11; #1;
      chk("rst_r5_clear", rdata1, 32'h0);
      chk("rst_r11_busy", 32'(rbusy2), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
